mult_div_ctrl: RTL and testbench
================================

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 SHALL have parameter DIV_TIMEOUT, default 31, max cycles in BUSY before forced abort.
REQ-002 SHALL have ports: clk  in  1  system clock; rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: flush  in  1  pipeline flush; req_valid  in  1  EX-stage mult/div request; req_funct  in  6  FUNCT/FUNCT2 code; req_op1, req_op2  in  32  operands.
REQ-004 SHALL have ports: stall  out  1  hold pipeline; gpr_result  out  32  low word for MUL; gpr_valid  out  1  gpr_result valid.
REQ-005 SHALL have ports: mdu_funct  out  6; mdu_op1, mdu_op2  out  32; mdu_hi, mdu_lo  out  32; mdu_flush  out  1; mdu_done  in  1; mdu_result  in  64 {hi,lo}.
REQ-006 SHALL have ports: wb_hi_we, wb_lo_we  in  1  MTHI/MTLO commit; wb_data  in  32; hi, lo  out  32  architectural HI/LO.
REQ-007 SHALL have port: timeout  out  1  one-cycle pulse on forced abort.

Function
REQ-008 SHALL implement states IDLE, BUSY, DONE.
REQ-009 SHALL accept a request in IDLE when req_valid and req_funct is MULT/MULTU/DIV/DIVU/MUL/MADD/MADDU/MSUB/MSUBU; other functs SHALL be ignored.
REQ-010 SHALL assert stall combinationally in the accept cycle and throughout BUSY; stall SHALL be 0 in IDLE without accept and in DONE.
REQ-011 SHALL latch funct and operands on accept; in BUSY, mdu_funct/op1/op2 SHALL drive latched values, otherwise mdu_funct = 0.
REQ-012 SHALL drive mdu_hi/mdu_lo from live HI/LO registers.
REQ-013 SHALL, in BUSY with mdu_done=1, go to DONE and capture mdu_result: HI/LO-writing functs update {hi,lo}; MUL leaves HI/LO unchanged and drives gpr_result = mdu_result[31:0].
REQ-014 SHALL assert gpr_valid exactly in the DONE cycle for MUL only; DONE SHALL always return to IDLE next cycle (mdu_funct = 0 there, clearing datapath done flag).
REQ-015 SHALL count BUSY cycles; on reaching DIV_TIMEOUT without mdu_done, pulse timeout and mdu_flush, return to IDLE, leave HI/LO unchanged.
REQ-016 SHALL, on flush in any state, assert mdu_flush that cycle, go to IDLE next edge, discard the pending result; flush SHALL win over a simultaneous mdu_done or accept.
REQ-017 SHALL apply wb_hi_we/wb_lo_we to hi/lo in any state; when same-cycle as a REQ-013 capture, the capture SHALL win.

Reset
REQ-018 SHALL, while rst=1, force state IDLE, hi=lo=0, latched funct/operands=0, counter=0, stall=0, gpr_valid=0, gpr_result=0, timeout=0, mdu_funct=0.
REQ-019 SHALL drive mdu_flush=1 while rst=1; reset mid-BUSY SHALL discard the operation.

Configuration
REQ-020 SHALL honour macro MDU_DIV0_FAST_EN: when defined, DIV/DIVU with req_op2=0 SHALL bypass the datapath, go IDLE->DONE in one cycle, set hi=req_op1, lo=32'hFFFFFFFF; when undefined, such divides SHALL issue normally and capture whatever mdu_result returns.

Structure
REQ-021 SHALL take FUNCT/FUNCT2 codes, state encoding, data widths from shared package mdu_pkg.
REQ-022 SHALL place HI/LO registers with write-priority logic in sub-module mdu_hilo_regs.

Verification
REQ-023 MULT 0xFFFFFFFE x 3, mdu_done after 1 cycle -> stall 2 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-024 DIVU 100/7, mdu_done after 17 BUSY cycles -> stall 18 cycles, hi=2, lo=14.
REQ-025 MUL 6x7 -> gpr_valid one cycle, gpr_result=42, hi/lo unchanged.
REQ-026 flush on BUSY cycle 5 of DIV, mdu_done same cycle -> mdu_flush=1, IDLE next cycle, HI/LO unchanged.
REQ-027 wb_hi_we with wb_data=0x1234 same cycle as MULT capture of hi=0x5 -> hi=0x5; mdu_done withheld 31 cycles -> timeout pulse.
REQ-028 DIV 9/0 with MDU_DIV0_FAST_EN -> stall 1 cycle, hi=9, lo=0xFFFFFFFF.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide controller: operand widths,
// FUNCT/FUNCT2 codes, FSM state encoding and small decode helpers.
package mdu_pkg;

    localparam int XLEN    = 32;
    localparam int FUNCT_W = 6;

    // SPECIAL group (FUNCT)
    localparam logic [FUNCT_W-1:0] F_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] F_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] F_DIV   = 6'h1A;
    localparam logic [FUNCT_W-1:0] F_DIVU  = 6'h1B;

    // SPECIAL2 group (FUNCT2) carried with bit 5 set so the codes never alias
    // the SPECIAL group or the idle code 0 on mdu_funct.
    localparam logic [FUNCT_W-1:0] F_MADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] F_MADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] F_MUL   = 6'h22;
    localparam logic [FUNCT_W-1:0] F_MSUB  = 6'h24;
    localparam logic [FUNCT_W-1:0] F_MSUBU = 6'h25;

    localparam logic [FUNCT_W-1:0] F_NONE  = 6'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_mdu_funct(input logic [FUNCT_W-1:0] f);
        case (f)
            F_MULT, F_MULTU, F_DIV, F_DIVU, F_MUL,
            F_MADD, F_MADDU, F_MSUB, F_MSUBU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_funct(input logic [FUNCT_W-1:0] f);
        return (f == F_DIV) || (f == F_DIVU);
    endfunction

endpackage

// File: rtl/mdu_hilo_regs.sv
// Architectural HI/LO registers. A result capture from the multiply/divide
// unit overrides an MTHI/MTLO commit arriving in the same cycle.
module mdu_hilo_regs
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            cap_we,
    input  logic [XLEN-1:0] cap_hi,
    input  logic [XLEN-1:0] cap_lo,
    input  logic            wb_hi_we,
    input  logic            wb_lo_we,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    // HI/LO update: capture first, otherwise independent MTHI/MTLO writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (cap_we) begin
            hi <= cap_hi;
            lo <= cap_lo;
        end else begin
            if (wb_hi_we) hi <= wb_data;
            if (wb_lo_we) lo <= wb_data;
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multiply/divide sequencing controller: accepts EX-stage mult/div requests,
// stalls the pipeline while the external datapath works, commits results to
// HI/LO or the GPR path, and aborts on flush or on a BUSY-cycle timeout.
// Optional feature macro: MDU_DIV0_FAST_EN (divide-by-zero bypass).
//
// state | meaning
// IDLE  | waiting for a request; accept cycle stalls combinationally
// BUSY  | datapath running on latched funct/operands; timeout counter live
// DONE  | one-cycle commit slot; gpr_valid for MUL, datapath sees funct 0
module mult_div_ctrl
    import mdu_pkg::*;
#(
    parameter int DIV_TIMEOUT = 31
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               req_valid,
    input  logic [FUNCT_W-1:0] req_funct,
    input  logic [XLEN-1:0]    req_op1,
    input  logic [XLEN-1:0]    req_op2,
    output logic               stall,
    output logic [XLEN-1:0]    gpr_result,
    output logic               gpr_valid,
    output logic [FUNCT_W-1:0] mdu_funct,
    output logic [XLEN-1:0]    mdu_op1,
    output logic [XLEN-1:0]    mdu_op2,
    output logic [XLEN-1:0]    mdu_hi,
    output logic [XLEN-1:0]    mdu_lo,
    output logic               mdu_flush,
    input  logic               mdu_done,
    input  logic [2*XLEN-1:0]  mdu_result,
    input  logic               wb_hi_we,
    input  logic               wb_lo_we,
    input  logic [XLEN-1:0]    wb_data,
    output logic [XLEN-1:0]    hi,
    output logic [XLEN-1:0]    lo,
    output logic               timeout
);

    localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

    mdu_state_e         state, state_nxt;
    logic [FUNCT_W-1:0] funct_q;
    logic [XLEN-1:0]    op1_q, op2_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic               cap_we;
    logic [XLEN-1:0]    cap_hi, cap_lo;
    logic               gpr_cap;

    // state register; async reset abandons any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // next state, handshakes and capture strobes; flush overrides done/accept
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        stall     = 1'b0;
        timeout   = 1'b0;
        gpr_valid = 1'b0;
        gpr_cap   = 1'b0;
        cap_we    = 1'b0;
        cap_hi    = mdu_result[2*XLEN-1:XLEN];
        cap_lo    = mdu_result[XLEN-1:0];
        mdu_funct = F_NONE;
        mdu_flush = rst | flush;

        case (state)
            ST_IDLE: begin
                if (!rst && !flush && req_valid && is_mdu_funct(req_funct)) begin
                    accept = 1'b1;
                    stall  = 1'b1;
`ifdef MDU_DIV0_FAST_EN
                    if (is_div_funct(req_funct) && (req_op2 == '0)) begin
                        state_nxt = ST_DONE;
                        cap_we    = 1'b1;
                        cap_hi    = req_op1;
                        cap_lo    = '1;
                    end else begin
                        state_nxt = ST_BUSY;
                    end
`else
                    state_nxt = ST_BUSY;
`endif
                end
            end
            ST_BUSY: begin
                stall     = 1'b1;
                mdu_funct = funct_q;
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (mdu_done) begin
                    state_nxt = ST_DONE;
                    if (funct_q == F_MUL) gpr_cap = 1'b1;
                    else                  cap_we  = 1'b1;
                end else if (cnt_q == '0) begin
                    timeout   = 1'b1;
                    mdu_flush = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                gpr_valid = (funct_q == F_MUL) && !flush;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // request latch; operands stay on mdu_op1/op2, only funct is gated by BUSY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct_q <= F_NONE;
            op1_q   <= '0;
            op2_q   <= '0;
        end else if (accept) begin
            funct_q <= req_funct;
            op1_q   <= req_op1;
            op2_q   <= req_op2;
        end
    end

    // BUSY-cycle down-counter; zero in BUSY marks the last allowed cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= CNT_W'(DIV_TIMEOUT - 1);
        end else if ((state == ST_BUSY) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // MUL result goes to the GPR path instead of HI/LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          gpr_result <= '0;
        else if (gpr_cap) gpr_result <= mdu_result[XLEN-1:0];
    end

    assign mdu_op1 = op1_q;
    assign mdu_op2 = op2_q;
    assign mdu_hi  = hi;
    assign mdu_lo  = lo;

    mdu_hilo_regs u_hilo (
        .clk      (clk),
        .rst      (rst),
        .cap_we   (cap_we),
        .cap_hi   (cap_hi),
        .cap_lo   (cap_lo),
        .wb_hi_we (wb_hi_we),
        .wb_lo_we (wb_lo_we),
        .wb_data  (wb_data),
        .hi       (hi),
        .lo       (lo)
    );

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl. The bench plays the datapath and
// computes expected HI/LO/GPR values and stall lengths from the operation
// semantics. Expectations follow MDU_DIV0_FAST_EN if the bench is built with it.
module tb_mult_div_ctrl;
    import mdu_pkg::*;

    localparam int TMO = 31;
    localparam logic [63:0] DIV0_JUNK = 64'h0BAD_0BAD_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic [5:0]  req_funct;
    logic [31:0] req_op1, req_op2;
    logic        stall;
    logic [31:0] gpr_result;
    logic        gpr_valid;
    logic [5:0]  mdu_funct;
    logic [31:0] mdu_op1, mdu_op2, mdu_hi, mdu_lo;
    logic        mdu_flush;
    logic        mdu_done;
    logic [63:0] mdu_result;
    logic        wb_hi_we, wb_lo_we;
    logic [31:0] wb_data;
    logic [31:0] hi, lo;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hi, m_lo;
    logic [5:0]  funct_pool [0:11];

    always #5 clk = ~clk;

    mult_div_ctrl #(.DIV_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_funct  (req_funct),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .stall      (stall),
        .gpr_result (gpr_result),
        .gpr_valid  (gpr_valid),
        .mdu_funct  (mdu_funct),
        .mdu_op1    (mdu_op1),
        .mdu_op2    (mdu_op2),
        .mdu_hi     (mdu_hi),
        .mdu_lo     (mdu_lo),
        .mdu_flush  (mdu_flush),
        .mdu_done   (mdu_done),
        .mdu_result (mdu_result),
        .wb_hi_we   (wb_hi_we),
        .wb_lo_we   (wb_lo_we),
        .wb_data    (wb_data),
        .hi         (hi),
        .lo         (lo),
        .timeout    (timeout)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_is_op(input logic [5:0] f);
        return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MUL, F_MADD, F_MADDU, F_MSUB, F_MSUBU};
    endfunction

    // what a correct datapath would return for this operation
    function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] h, input logic [31:0] l);
        longint sa, sb, q, r;
        logic [63:0] sp, up, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sp  = sa * sb;
        up  = {32'd0, a} * {32'd0, b};
        acc = {h, l};
        case (f)
            F_MULT, F_MUL: return sp;
            F_MULTU:       return up;
            F_MADD:        return acc + sp;
            F_MADDU:       return acc + up;
            F_MSUB:        return acc - sp;
            F_MSUBU:       return acc - up;
            F_DIV: begin
                if (b == 0) return DIV0_JUNK;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            F_DIVU: begin
                if (b == 0) return DIV0_JUNK;
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // one request; done_at/flush_at count BUSY cycles from 1 (0 = never)
    task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int done_at, input int flush_at, input bit wb_clash, input logic [31:0] wbd);
        bit valid, fast, busy, flushed, done_path, timed, cap, wb_drv, stop;
        int e_stall, n, stalls, tmos, flushes, gvs, bad_if;
        logic [63:0] res;
        logic [31:0] gres, e_hi, e_lo;

        valid = ref_is_op(f);
`ifdef MDU_DIV0_FAST_EN
        fast = valid && (f == F_DIV || f == F_DIVU) && (b == 0);
`else
        fast = 1'b0;
`endif
        busy      = valid && !fast;
        res       = ref_result(f, a, b, m_hi, m_lo);
        flushed   = busy && flush_at > 0 && flush_at <= TMO && (done_at == 0 || flush_at <= done_at);
        done_path = busy && !flushed && done_at > 0 && done_at <= TMO;
        timed     = busy && !flushed && !done_path;
        wb_drv    = wb_clash && busy && done_at > 0 && done_at <= TMO && !(flush_at > 0 && flush_at < done_at);
        cap       = done_path && (f != F_MUL);

        e_hi = m_hi;
        e_lo = m_lo;
        if (wb_drv && !cap) begin e_hi = wbd; e_lo = wbd; end
        if (cap) {e_hi, e_lo} = res;
        if (fast) begin e_hi = a; e_lo = 32'hFFFF_FFFF; end
        e_stall = !valid ? 0 : fast ? 1 : 1 + (flushed ? flush_at : done_path ? done_at : TMO);

        @(negedge clk);
        req_valid = 1'b1;
        req_funct = f;
        req_op1   = a;
        req_op2   = b;
        #1;
        stalls  = int'(stall);
        bad_if  = (mdu_funct != F_NONE) ? 1 : 0;
        tmos    = 0;
        flushes = 0;
        gvs     = 0;
        gres    = 32'd0;
        check_val({tag, "/mdu_hilo"}, {mdu_hi, mdu_lo}, {m_hi, m_lo});

        n    = 0;
        stop = 1'b0;
        while (!stop && n < 80) begin
            @(negedge clk);
            n++;
            req_valid  = 1'b0;
            req_funct  = F_NONE;
            mdu_done   = busy && (n == done_at);
            mdu_result = mdu_done ? res : {$urandom, $urandom};
            flush      = busy && (n == flush_at);
            wb_hi_we   = wb_drv && (n == done_at);
            wb_lo_we   = wb_drv && (n == done_at);
            wb_data    = wbd;
            #1;
            if (stall) begin
                stalls++;
                if (mdu_funct != f || mdu_op1 != a || mdu_op2 != b) bad_if++;
            end else begin
                if (mdu_funct != F_NONE) bad_if++;
                stop = 1'b1;
            end
            tmos    += int'(timeout);
            flushes += int'(mdu_flush);
            if (gpr_valid) begin
                gvs++;
                gres = gpr_result;
            end
        end
        mdu_done = 1'b0;
        flush    = 1'b0;
        wb_hi_we = 1'b0;
        wb_lo_we = 1'b0;

        check_val({tag, "/ended"}, 64'(stop), 64'd1);
        check_val({tag, "/stall_cycles"}, 64'(stalls), 64'(e_stall));
        check_val({tag, "/timeout_pulses"}, 64'(tmos), 64'(timed ? 1 : 0));
        check_val({tag, "/mdu_flush_cycles"}, 64'(flushes), 64'((flushed || timed) ? 1 : 0));
        check_val({tag, "/gpr_valid_cycles"}, 64'(gvs), 64'((done_path && f == F_MUL) ? 1 : 0));
        if (done_path && f == F_MUL) check_val({tag, "/gpr_result"}, 64'(gres), {32'd0, res[31:0]});
        check_val({tag, "/hilo"}, {hi, lo}, {e_hi, e_lo});
        check_val({tag, "/datapath_if"}, 64'(bad_if), 64'd0);
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    task automatic do_wb(input bit hw, input bit lw, input logic [31:0] d);
        @(negedge clk);
        wb_hi_we = hw;
        wb_lo_we = lw;
        wb_data  = d;
        @(negedge clk);
        wb_hi_we = 1'b0;
        wb_lo_we = 1'b0;
        #1;
        if (hw) m_hi = d;
        if (lw) m_lo = d;
        check_val("wb_idle/hilo", {hi, lo}, {m_hi, m_lo});
    endtask

    task automatic reset_mid_busy();
        @(negedge clk);
        req_valid = 1'b1;
        req_funct = F_DIVU;
        req_op1   = 32'd1000;
        req_op2   = 32'd3;
        @(negedge clk);
        req_valid = 1'b0;
        req_funct = F_NONE;
        @(negedge clk);
        #1;
        check_val("rst_mid/busy_before", 64'(stall), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_mid/mdu_flush", 64'(mdu_flush), 64'd1);
        check_val("rst_mid/stall", 64'(stall), 64'd0);
        check_val("rst_mid/hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_val("rst_mid/idle_after", {58'd0, mdu_funct}, 64'd0);
        check_val("rst_mid/stall_after", 64'(stall), 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b1;
        req_funct  = F_MULT;
        req_op1    = 32'd3;
        req_op2    = 32'd4;
        mdu_done   = 1'b0;
        mdu_result = 64'd0;
        wb_hi_we   = 1'b0;
        wb_lo_we   = 1'b0;
        wb_data    = 32'd0;
        m_hi       = 32'd0;
        m_lo       = 32'd0;
        funct_pool = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MUL, F_MADD,
                       F_MADDU, F_MSUB, F_MSUBU, 6'h00, 6'h10, 6'h3F};

        repeat (3) @(negedge clk);
        #1;
        check_val("reset/stall", 64'(stall), 64'd0);
        check_val("reset/mdu_flush", 64'(mdu_flush), 64'd1);
        check_val("reset/hilo", {hi, lo}, 64'd0);
        check_val("reset/mdu_funct", {58'd0, mdu_funct}, 64'd0);
        check_val("reset/gpr", {31'd0, gpr_valid, gpr_result}, 64'd0);
        check_val("reset/timeout", 64'(timeout), 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        #1;
        check_val("post_reset/mdu_flush", 64'(mdu_flush), 64'd0);

        do_op("mult_neg",   F_MULT,  32'hFFFF_FFFE, 32'd3,  1, 0, 1'b0, 32'd0);
        do_op("divu_100_7", F_DIVU,  32'd100,       32'd7, 17, 0, 1'b0, 32'd0);
        do_op("mul_6x7",    F_MUL,   32'd6,         32'd7,  3, 0, 1'b0, 32'd0);
        do_op("div_flush",  F_DIV,   32'd50,        32'd3,  5, 5, 1'b0, 32'd0);
        do_op("mult_wbhi",  F_MULTU, 32'h5000_0000, 32'h10, 4, 0, 1'b1, 32'h1234);
        do_op("divu_tmo",   F_DIVU,  32'd10,        32'd3,  0, 0, 1'b0, 32'd0);
        do_op("div_by0",    F_DIV,   32'd9,         32'd0,  3, 0, 1'b0, 32'd0);
        do_op("done_at_tc", F_DIVU,  32'd77,        32'd5, TMO, 0, 1'b0, 32'd0);
        do_op("done_late",  F_DIV,   32'd77,        32'd5, TMO + 1, 0, 1'b0, 32'd0);
        do_op("bad_funct",  6'h10,   32'd1,         32'd2,  2, 0, 1'b0, 32'd0);
        do_op("mul_wb",     F_MUL,   32'd5,         32'd5,  2, 0, 1'b1, 32'hCAFE);
        do_wb(1'b1, 1'b0, 32'h0000_0010);
        do_wb(1'b0, 1'b1, 32'h0000_0020);
        do_op("madd",       F_MADD,  32'hFFFF_FFFF, 32'd2,  2, 0, 1'b0, 32'd0);
        do_op("msubu",      F_MSUBU, 32'd3,         32'd4,  1, 0, 1'b0, 32'd0);
        reset_mid_busy();

        for (int i = 0; i < 60; i++) begin
            logic [5:0]  f;
            logic [31:0] a, b;
            int          d, fa;
            f  = funct_pool[$urandom_range(0, 11)];
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            d  = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO - 1, TMO + 3) : $urandom_range(1, 12);
            fa = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 12) : 0;
            do_op($sformatf("rnd%0d", i), f, a, b, d, fa, ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
